// File: rtl/n64_poll_engine.sv
// N64 controller poll engine: sends a command over the open-drain line, then
// decodes the controller's pulse-width reply into con_data.
module n64_poll_engine #(
    parameter int                  CLK_PER_US = 25,
    parameter int                  CMD_BITS   = 8,
    parameter logic [CMD_BITS-1:0] CMD_WORD   = CMD_BITS'(8'h01),
    parameter int                  RESP_BITS  = 32,
    parameter int                  TIMEOUT_US = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 data_in,
    output logic                 drive_low,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [RESP_BITS-1:0] con_data
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TX_BIT    = 3'd1;
    localparam logic [2:0] S_TX_STOP   = 3'd2;
    localparam logic [2:0] S_RX_WAIT   = 3'd3;
    localparam logic [2:0] S_RX_SAMPLE = 3'd4;
    localparam logic [2:0] S_RX_HIGH   = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    // One shared counter: largest value is either the reply timeout or the
    // stuck-low limit, whichever is bigger.
    localparam int TO_CYC  = TIMEOUT_US * CLK_PER_US;
    localparam int LOW_MAX = 5 * CLK_PER_US;
    localparam int CNT_MAX = (TO_CYC > LOW_MAX) ? TO_CYC : LOW_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_MAX = (CMD_BITS > RESP_BITS) ? CMD_BITS : RESP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    localparam logic [CNT_W-1:0] US_1      = CNT_W'(CLK_PER_US);
    localparam logic [CNT_W-1:0] US_3      = CNT_W'(3 * CLK_PER_US);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(4 * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] STOP_END  = CNT_W'(3 * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(2 * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] LOW_LIM   = CNT_W'(LOW_MAX);
    localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TO_CYC - 1);
    localparam logic [IDX_W-1:0] TX_LAST   = IDX_W'(CMD_BITS - 1);
    localparam logic [IDX_W-1:0] RX_LAST   = IDX_W'(RESP_BITS);

    logic [2:0]           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [CMD_BITS-1:0]  tx_sr, tx_sr_nxt;
    logic [RESP_BITS-1:0] shadow, shadow_nxt;
    logic [1:0]           err_nxt;
    logic [2:0]           sync;
    logic                 line, fall, drive_nxt;

    assign line  = sync[1];
    assign fall  = sync[2] & ~sync[1];
    assign busy  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERROR);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        tx_sr_nxt  = tx_sr;
        shadow_nxt = shadow;
        err_nxt    = err_code;
        case (state)
            S_IDLE: if (start) begin
                if (line) begin
                    state_nxt = S_TX_BIT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    tx_sr_nxt = CMD_WORD;
                    err_nxt   = 2'b00;
                end else begin
                    state_nxt = S_ERROR;
                    err_nxt   = 2'b11;
                end
            end
            S_TX_BIT: if (cnt == BIT_END) begin
                cnt_nxt   = '0;
                tx_sr_nxt = tx_sr << 1;
                if (idx == TX_LAST) state_nxt = S_TX_STOP;
                else                idx_nxt   = idx + 1'b1;
            end else cnt_nxt = cnt + 1'b1;
            S_TX_STOP: if (cnt == STOP_END) begin
                state_nxt = S_RX_WAIT;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end else cnt_nxt = cnt + 1'b1;
            S_RX_WAIT: if (fall) begin
                state_nxt = S_RX_SAMPLE;
                cnt_nxt   = '0;
            end else if (cnt == TO_END) begin
                state_nxt = S_ERROR;
                err_nxt   = 2'b01;
            end else cnt_nxt = cnt + 1'b1;
            S_RX_SAMPLE: begin
                // cnt keeps running into RX_HIGH so the low-time limit is
                // measured from the falling edge, not from the sample point
                cnt_nxt = cnt + 1'b1;
                if (cnt == SAMPLE_AT) begin
                    shadow_nxt = RESP_BITS'({shadow, line});
                    idx_nxt    = idx + 1'b1;
                    state_nxt  = S_RX_HIGH;
                end
            end
            S_RX_HIGH: if (line) begin
                state_nxt = (idx == RX_LAST) ? S_DONE : S_RX_WAIT;
                cnt_nxt   = '0;
            end else if (cnt == LOW_LIM) begin
                state_nxt = S_ERROR;
                err_nxt   = 2'b10;
            end else cnt_nxt = cnt + 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line drive is registered from the next state so the pad never sees decode glitches.
    always_comb begin
        drive_nxt = 1'b0;
        if (state_nxt == S_TX_BIT)
            drive_nxt = cnt_nxt < (tx_sr_nxt[CMD_BITS-1] ? US_1 : US_3);
        else if (state_nxt == S_TX_STOP)
            drive_nxt = cnt_nxt < US_1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            tx_sr     <= '0;
            shadow    <= '0;
            err_code  <= 2'b00;
            con_data  <= '0;
            drive_low <= 1'b0;
            sync      <= 3'b111;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            tx_sr     <= tx_sr_nxt;
            shadow    <= shadow_nxt;
            err_code  <= err_nxt;
            drive_low <= drive_nxt;
            sync      <= {sync[1:0], data_in};
            if (state_nxt == S_DONE) con_data <= shadow;
        end
    end
endmodule

// File: tb/tb_n64_poll_engine.sv
// Directed bench for n64_poll_engine at 4 clocks/us with an open-drain line model.
module tb_n64_poll_engine;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ctrl_low = 1'b0;
    logic        data_in;
    logic        drive_low, busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] con_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int dl_cnt = 0;
    int busy_at_done = 0;

    logic [159:0] cap, exp_pat;
    int snap_done, snap_err, snap_dl;

    n64_poll_engine #(.CLK_PER_US(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
        .drive_low(drive_low), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .con_data(con_data)
    );

    assign data_in = ~drive_low & ~ctrl_low;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (done) begin
                done_cnt++;
                if (busy !== 1'b0) busy_at_done++;
            end
            if (error) err_cnt++;
            if (drive_low) dl_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic b);
        ctrl_low = 1'b1;
        repeat (b ? 4 : 12) tick();
        ctrl_low = 1'b0;
        repeat (b ? 12 : 4) tick();
    endtask

    task automatic reply(input logic [31:0] w);
        repeat (4) tick();
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
        ctrl_low = 1'b1;
        repeat (4) tick();
        ctrl_low = 1'b0;
        repeat (8) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_drive_low", drive_low, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done_error", {done, error}, 2'b00);
        check("rst_err_code", err_code, 2'b00);
        check("rst_con_data", con_data, 32'h0);
        reset_n = 1'b1;
        repeat (4) tick();

        // Poll with reply 0x800000FF; a second start during TX must be dropped.
        pulse_start();
        check("tx_busy_rise", busy, 1'b1);
        cap = '0;
        exp_pat = '0;
        cap[0] = drive_low;
        for (int k = 1; k < 140; k++) begin
            start = (k == 50);
            tick();
            start = 1'b0;
            cap[k] = drive_low;
        end
        for (int k = 0; k < 140; k++) begin
            if (k < 128) exp_pat[k] = ((k % 16) < (((k / 16) == 7) ? 4 : 12));
            else         exp_pat[k] = (k < 132);
        end
        check("tx_pattern", cap, exp_pat);
        tick();
        reply(32'h8000_00FF);
        repeat (20) tick();
        check("poll_done_cnt", done_cnt, 1);
        check("poll_err_cnt", err_cnt, 0);
        check("poll_con_data", con_data, 32'h8000_00FF);
        check("poll_busy_at_done", busy_at_done, 0);
        check("poll_no_requeue", busy, 1'b0);
        check("poll_err_code", err_code, 2'b00);

        // No reply: timeout 400 cycles after entering RX_WAIT.
        pulse_start();
        repeat (140) tick();
        repeat (399) tick();
        check("to_busy_before", busy, 1'b1);
        check("to_error_before", error, 1'b0);
        tick();
        check("to_error_pulse", error, 1'b1);
        check("to_err_code", err_code, 2'b01);
        check("to_con_data_kept", con_data, 32'h8000_00FF);
        check("to_busy_low", busy, 1'b0);
        tick();
        check("to_error_one_cycle", error, 1'b0);

        // Line held low 24 cycles at bit 5.
        snap_done = done_cnt;
        pulse_start();
        repeat (140) tick();
        repeat (4) tick();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        ctrl_low = 1'b1;
        repeat (23) tick();
        check("stuck_error_early", error, 1'b0);
        tick();
        check("stuck_error_pulse", error, 1'b1);
        check("stuck_err_code", err_code, 2'b10);
        repeat (2) tick();
        ctrl_low = 1'b0;
        repeat (10) tick();
        check("stuck_no_done", done_cnt, snap_done);
        check("stuck_con_data_kept", con_data, 32'h8000_00FF);

        // Line already low when start arrives.
        ctrl_low = 1'b1;
        repeat (4) tick();
        snap_dl = dl_cnt;
        pulse_start();
        check("low_start_error", error, 1'b1);
        check("low_start_err_code", err_code, 2'b11);
        check("low_start_busy", busy, 1'b0);
        repeat (3) tick();
        check("low_start_no_drive", dl_cnt, snap_dl);
        ctrl_low = 1'b0;
        repeat (4) tick();

        // Asynchronous reset while the engine is pulling the line low.
        pulse_start();
        repeat (5) tick();
        check("rst_mid_driving", drive_low, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_release", drive_low, 1'b0);
        check("rst_mid_outputs", {busy, done, error, err_code}, 5'b0);
        check("rst_mid_con_data", con_data, 32'h0);
        snap_done = done_cnt;
        snap_err = err_cnt;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("rst_mid_no_pulse", {done_cnt, err_cnt}, {snap_done, snap_err});
        pulse_start();
        repeat (140) tick();
        reply(32'h1234_5678);
        repeat (20) tick();
        check("post_rst_done", done_cnt, snap_done + 1);
        check("post_rst_con_data", con_data, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
